hazard_ctrl: RTL
================

Name: hazard_ctrl

Overview:
- Pipeline sequencing controller for the 5-stage MIPS core. It sits beside the forwarding unit and covers the hazards forwarding cannot resolve.
- Generates PC/IF-ID write enables, the ID/EX bubble and IF/ID and ID/EX flushes for three cases: load-use, taken branch/jump, and the shared multi-cycle multiply/divide unit.
- Owns the mult/div busy sequencing (start pulse, latency countdown, HI/LO consumer stall) and a saturating stall-cycle counter for performance measurement.

Parameters:
- MD_LAT, 4, mult/div latency in cycles from MD_Start to result valid in HI/LO; legal range 2..15.
- CNT_W, 16, width of the stall-cycle counter.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous, active-low reset.
- IFID_Rs  in  5  Rs of the instruction in ID.
- IFID_Rt  in  5  Rt of the instruction in ID.
- ID_MulDiv  in  1  instruction in ID is mult/multu/div/divu.
- ID_UsesHiLo  in  1  instruction in ID is mfhi/mflo/mthi/mtlo.
- IDEX_Rt  in  5  destination Rt of the instruction in EX.
- IDEX_MemRead  in  1  instruction in EX is a load.
- IDEX_MulDiv  in  1  instruction in EX is mult/div; issue point.
- EX_BranchTaken  in  1  branch or jump resolved taken in EX this cycle.
- PCWrite  out  1  PC update enable.
- IFIDWrite  out  1  IF/ID register enable.
- IDEX_Bubble  out  1  zero the control fields written into ID/EX.
- IFID_Flush  out  1  clear IF/ID to a nop.
- IDEX_Flush  out  1  clear ID/EX to a nop.
- MD_Start  out  1  one-cycle start pulse to the mult/div unit.
- MD_Busy  out  1  mult/div operation in flight.
- StallCnt  out  CNT_W  cycles in which PCWrite=0, saturating.

Behaviour:
- State: IDLE or MD_RUN; md_cnt is 4 bits.
- Reset: any clock edge with rst=0 → state=IDLE, md_cnt=0, StallCnt=0.
- While rst=0, all combinational outputs are forced: PCWrite=0, IFIDWrite=0, and every other 1-bit output 0.
- Outputs are combinational from the current state and inputs, so a stall takes effect in the same cycle.
- Defaults: PCWrite=1, IFIDWrite=1, all other 1-bit outputs 0.
- Priority, highest first:
  1. EX_BranchTaken → IFID_Flush=1, IDEX_Flush=1, PCWrite=1, IFIDWrite=1; any stall condition is ignored because the stalled ID instruction is squashed.
  2. Mult/div stall → PCWrite=0, IFIDWrite=0, IDEX_Bubble=1.
  3. Load-use stall → PCWrite=0, IFIDWrite=0, IDEX_Bubble=1.
- Load-use condition: IDEX_MemRead & IDEX_Rt≠0 & (IDEX_Rt==IFID_Rs | IDEX_Rt==IFID_Rt). Lasts exactly one cycle, because the bubble clears IDEX_MemRead.
- IDLE state:
  - If IDEX_MulDiv=1, assert MD_Start=1, load md_cnt=MD_LAT-1 and go to MD_RUN next cycle.
  - MD_Busy=0 in IDLE, including the MD_Start cycle.
- MD_RUN state:
  - MD_Busy=1.
  - Mult/div stall condition: ID_UsesHiLo | ID_MulDiv.
  - md_cnt decrements each cycle. When md_cnt==1 the next state is IDLE, so MD_Busy is high for exactly MD_LAT-1 cycles.
  - A HI/LO consumer in ID stalls until MD_Busy falls and is released the cycle after.
- IDEX_MulDiv=1 while in MD_RUN cannot occur, because ID_MulDiv stalls it. The bench asserts this never happens.
- A taken branch during MD_RUN does not abort the in-flight operation; the counter keeps running.
- StallCnt increments on every non-reset cycle with PCWrite=0 and holds at all-ones.
- Reset asserted mid-MD_RUN → IDLE next edge, no MD_Start. The mult/div unit is reset by the same rst.

Decomposition:
- Shared package holds: the state encoding (IDLE=1'b0, MD_RUN=1'b1), the REG_ZERO=5'd0 constant, and the MD_LAT default.
- One natural sub-module: md_sequencer, which owns the state, md_cnt, MD_Start and MD_Busy and exports md_stall.
- The hazard priority mux and StallCnt stay in the top level.

Test Plan:
- Load-use: `lw $5` in EX (IDEX_MemRead=1, IDEX_Rt=5) with IFID_Rs=5 → exactly one cycle of PCWrite=0, IFIDWrite=0, IDEX_Bubble=1; StallCnt=1.
- Load-use with IDEX_Rt=0 and IFID_Rs=0 → no stall; PCWrite=1.
- Mult/div, MD_LAT=4: IDEX_MulDiv pulse, then ID_UsesHiLo held → MD_Start for 1 cycle, MD_Busy for 3 cycles, PCWrite=0 for those 3 cycles, PCWrite=1 on the 4th; StallCnt=3.
- Branch-over-stall: EX_BranchTaken=1 in the same cycle as a load-use match → IFID_Flush=1, IDEX_Flush=1, PCWrite=1, IDEX_Bubble=0; StallCnt unchanged.
- Reset mid-op: assert rst=0 in the 2nd MD_RUN cycle → MD_Busy=0 next cycle, all outputs 0 while rst=0, StallCnt=0. After release, PCWrite=1.
- Saturation with CNT_W=4: hold ID_UsesHiLo through repeated mult/div ops until StallCnt reaches 15 → StallCnt stays at 15.

Source files
------------

// File: rtl/hazard_ctrl_pkg.sv
// hazard_ctrl_pkg: shared state encoding and constants for the hazard controller
package hazard_ctrl_pkg;
   typedef enum logic {IDLE = 1'b0, MD_RUN = 1'b1} md_state_t;
   localparam logic [4:0] REG_ZERO = 5'd0;
   localparam int MD_LAT_DEF = 4;
endpackage

// File: rtl/hazard_ctrl_md_sequencer.sv
// md_sequencer: mult/div issue, latency countdown and HI/LO consumer stall
module md_sequencer
   import hazard_ctrl_pkg::*;
#(
   parameter int MD_LAT = MD_LAT_DEF
) (
   input  logic clk,
   input  logic rst,
   input  logic ID_MulDiv,
   input  logic ID_UsesHiLo,
   input  logic IDEX_MulDiv,
   output logic MD_Start,
   output logic MD_Busy,
   output logic md_stall
);
   md_state_t state, state_nxt;
   logic [3:0] md_cnt, md_cnt_nxt;
   // state and countdown registers, cleared by the shared reset
   always_ff @(posedge clk) begin
      if (!rst) begin
         state  <= IDLE;
         md_cnt <= 4'd0;
      end else begin
         state  <= state_nxt;
         md_cnt <= md_cnt_nxt;
      end
   end
   // issue on IDEX_MulDiv, count down while running, stall HI/LO users and new mult/div
   always_comb begin
      state_nxt  = state;
      md_cnt_nxt = md_cnt;
      MD_Start   = 1'b0;
      MD_Busy    = 1'b0;
      md_stall   = 1'b0;
      if (rst) begin
         if (state == IDLE) begin
            if (IDEX_MulDiv) begin
               MD_Start   = 1'b1;
               md_cnt_nxt = 4'(MD_LAT - 1);
               state_nxt  = MD_RUN;
            end
         end else begin
            MD_Busy    = 1'b1;
            md_stall   = ID_UsesHiLo | ID_MulDiv;
            md_cnt_nxt = md_cnt - 4'd1;
            state_nxt  = (md_cnt == 4'd1) ? IDLE : MD_RUN;
         end
      end
   end
endmodule

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: stall/flush control for load-use, taken branch and mult/div hazards
module hazard_ctrl
   import hazard_ctrl_pkg::*;
#(
   parameter int MD_LAT = MD_LAT_DEF,
   parameter int CNT_W  = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [4:0]       IFID_Rs,
   input  logic [4:0]       IFID_Rt,
   input  logic             ID_MulDiv,
   input  logic             ID_UsesHiLo,
   input  logic [4:0]       IDEX_Rt,
   input  logic             IDEX_MemRead,
   input  logic             IDEX_MulDiv,
   input  logic             EX_BranchTaken,
   output logic             PCWrite,
   output logic             IFIDWrite,
   output logic             IDEX_Bubble,
   output logic             IFID_Flush,
   output logic             IDEX_Flush,
   output logic             MD_Start,
   output logic             MD_Busy,
   output logic [CNT_W-1:0] StallCnt
);
   logic md_stall, load_use, stall, branch;
   md_sequencer #(.MD_LAT(MD_LAT)) u_md (
      .clk         (clk),
      .rst         (rst),
      .ID_MulDiv   (ID_MulDiv),
      .ID_UsesHiLo (ID_UsesHiLo),
      .IDEX_MulDiv (IDEX_MulDiv),
      .MD_Start    (MD_Start),
      .MD_Busy     (MD_Busy),
      .md_stall    (md_stall)
   );
   // a taken branch squashes the ID instruction, so it overrides any stall
   always_comb begin
      load_use    = IDEX_MemRead && IDEX_Rt != REG_ZERO && (IDEX_Rt == IFID_Rs || IDEX_Rt == IFID_Rt);
      branch      = rst && EX_BranchTaken;
      stall       = rst && !EX_BranchTaken && (md_stall || load_use);
      PCWrite     = rst && !stall;
      IFIDWrite   = rst && !stall;
      IDEX_Bubble = stall;
      IFID_Flush  = branch;
      IDEX_Flush  = branch;
   end
   // saturating count of cycles in which the PC was held
   always_ff @(posedge clk) begin
      if (!rst) StallCnt <= '0;
      else if (stall && StallCnt != '1) StallCnt <= StallCnt + 1'b1;
   end
endmodule
